fc_cif_udiv_64ns_32ns_seq: RTL and testbench



---
 rtl/fc_cif_div_pkg.sv | 30 +++
 rtl/fc_cif_udiv_step.sv | 28 ++
 rtl/fc_cif_udiv_64ns_32ns_seq.sv | 161 ++++++++++++++++
 tb/tb_fc_cif_udiv_64ns_32ns_seq.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/fc_cif_div_pkg.sv
// Shared definitions for the FC_CIF sequential unsigned divider.
// Optional build macro: FC_CIF_UDIV_RADIX4_EN (two quotient bits per BUSY cycle).
package fc_cif_div_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } div_state_e;

    localparam int DEF_DIVIDEND_WIDTH = 64;
    localparam int DEF_DIVISOR_WIDTH  = 32;

`ifdef FC_CIF_UDIV_RADIX4_EN
    localparam bit RADIX4_EN = 1'b1;
`else
    localparam bit RADIX4_EN = 1'b0;
`endif

    // Quotient bits retired per enabled BUSY cycle.
    localparam int BITS_PER_CYCLE = RADIX4_EN ? 2 : 1;

    // Accept edge to the edge that raises done, for a given dividend width.
    function automatic int latency_for(input int dividend_width);
        return dividend_width / BITS_PER_CYCLE + 1;
    endfunction

    localparam int LATENCY = DEF_DIVIDEND_WIDTH / BITS_PER_CYCLE + 1;

endpackage

// File: rtl/fc_cif_udiv_step.sv
// One combinational restoring-division step: shift {rem,q} left by one,
// try to subtract the divisor and retire one quotient bit.
module fc_cif_udiv_step #(
    parameter int DIVIDEND_WIDTH = 64,
    parameter int DIVISOR_WIDTH  = 32
) (
    input  logic [DIVISOR_WIDTH:0]    rem_i,
    input  logic [DIVIDEND_WIDTH-1:0] q_i,
    input  logic [DIVISOR_WIDTH-1:0]  divisor_i,
    output logic [DIVISOR_WIDTH:0]    rem_o,
    output logic [DIVIDEND_WIDTH-1:0] q_o
);

    logic [DIVISOR_WIDTH+1:0] rem_sh;
    logic [DIVISOR_WIDTH:0]   diff;
    logic                     fits;

    // Trial subtraction; the difference only matters when it is non-negative,
    // in which case it is narrower than the divisor, so DIVISOR_WIDTH+1 bits suffice.
    always_comb begin
        rem_sh = {rem_i, q_i[DIVIDEND_WIDTH-1]};
        fits   = (rem_sh >= {2'b00, divisor_i});
        diff   = rem_sh[DIVISOR_WIDTH:0] - {1'b0, divisor_i};
        rem_o  = fits ? diff : rem_sh[DIVISOR_WIDTH:0];
        q_o    = {q_i[DIVIDEND_WIDTH-2:0], fits};
    end

endmodule

// File: rtl/fc_cif_udiv_64ns_32ns_seq.sv
// Sequential unsigned restoring divider, 64/32 -> 64 quotient + 32 remainder,
// with start/ready/done handshake and clock enable.
// Optional build macro: FC_CIF_UDIV_RADIX4_EN chains two steps per cycle.
module fc_cif_udiv_64ns_32ns_seq
    import fc_cif_div_pkg::*;
#(
    parameter int DIVIDEND_WIDTH = DEF_DIVIDEND_WIDTH,
    parameter int DIVISOR_WIDTH  = DEF_DIVISOR_WIDTH
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      ce,
    input  logic                      start,
    input  logic [DIVIDEND_WIDTH-1:0] din0,
    input  logic [DIVISOR_WIDTH-1:0]  din1,
    output logic                      ready,
    output logic                      done,
    output logic [DIVIDEND_WIDTH-1:0] quot,
    output logic [DIVISOR_WIDTH-1:0]  rem,
    output logic                      div0
);

`ifdef FC_CIF_UDIV_RADIX4_EN
    localparam int STEPS = 2;
`else
    localparam int STEPS = 1;
`endif
    localparam int              CNT_W    = $clog2(DIVIDEND_WIDTH + 1);
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(DIVIDEND_WIDTH / STEPS);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    div_state_e                state_q, state_d;
    logic [CNT_W-1:0]          cnt_q, cnt_d;
    logic [DIVIDEND_WIDTH-1:0] q_work_q, q_work_d;
    logic [DIVISOR_WIDTH:0]    rem_work_q, rem_work_d;
    logic [DIVISOR_WIDTH-1:0]  divisor_q, divisor_d;
    logic                      div0_work_q, div0_work_d;
    logic [DIVIDEND_WIDTH-1:0] quot_q, quot_d;
    logic [DIVISOR_WIDTH-1:0]  rem_q, rem_d;
    logic                      div0_q, div0_d;
    logic                      done_q, done_d;
    logic                      accept;

    // Chain of restoring steps: element 0 is the current working state,
    // element STEPS is the state after this cycle's iterations.
    logic [DIVISOR_WIDTH:0]    chain_rem [STEPS+1];
    logic [DIVIDEND_WIDTH-1:0] chain_q   [STEPS+1];

    assign chain_rem[0] = rem_work_q;
    assign chain_q[0]   = q_work_q;

    genvar gi;
    generate
        for (gi = 0; gi < STEPS; gi++) begin : g_step
            fc_cif_udiv_step #(
                .DIVIDEND_WIDTH(DIVIDEND_WIDTH),
                .DIVISOR_WIDTH (DIVISOR_WIDTH)
            ) u_step (
                .rem_i    (chain_rem[gi]),
                .q_i      (chain_q[gi]),
                .divisor_i(divisor_q),
                .rem_o    (chain_rem[gi+1]),
                .q_o      (chain_q[gi+1])
            );
        end
    endgenerate

    assign ready  = (state_q != BUSY);
    assign accept = start && (state_q != BUSY);

    // Next-state and datapath: iterate in BUSY, publish results in DONE,
    // and (re)load operands whenever a start is accepted.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        q_work_d    = q_work_q;
        rem_work_d  = rem_work_q;
        divisor_d   = divisor_q;
        div0_work_d = div0_work_q;
        quot_d      = quot_q;
        rem_d       = rem_q;
        div0_d      = div0_q;
        done_d      = 1'b0;

        case (state_q)
            BUSY: begin
                // A zero count means nothing left to iterate (divide-by-zero
                // parks here for one cycle with its result already loaded).
                if (cnt_q != '0) begin
                    q_work_d   = chain_q[STEPS];
                    rem_work_d = chain_rem[STEPS];
                    cnt_d      = cnt_q - CNT_ONE;
                end
                if (cnt_q <= CNT_ONE) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                quot_d  = q_work_q;
                rem_d   = rem_work_q[DIVISOR_WIDTH-1:0];
                div0_d  = div0_work_q;
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Accept overrides the DONE -> IDLE transition for back-to-back ops;
        // the published results above read the old working registers.
        if (accept) begin
            state_d   = BUSY;
            divisor_d = din1;
            if (din1 == '0) begin
                q_work_d    = '1;
                rem_work_d  = {1'b0, din0[DIVISOR_WIDTH-1:0]};
                div0_work_d = 1'b1;
                cnt_d       = '0;
            end else begin
                q_work_d    = din0;
                rem_work_d  = '0;
                div0_work_d = 1'b0;
                cnt_d       = CNT_INIT;
            end
        end
    end

    // State and data registers; reset wins over ce, ce low freezes everything.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            q_work_q    <= '0;
            rem_work_q  <= '0;
            divisor_q   <= '0;
            div0_work_q <= 1'b0;
            quot_q      <= '0;
            rem_q       <= '0;
            div0_q      <= 1'b0;
            done_q      <= 1'b0;
        end else if (ce) begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            q_work_q    <= q_work_d;
            rem_work_q  <= rem_work_d;
            divisor_q   <= divisor_d;
            div0_work_q <= div0_work_d;
            quot_q      <= quot_d;
            rem_q       <= rem_d;
            div0_q      <= div0_d;
            done_q      <= done_d;
        end
    end

    assign done = done_q;
    assign quot = quot_q;
    assign rem  = rem_q;
    assign div0 = div0_q;

endmodule

// File: tb/tb_fc_cif_udiv_64ns_32ns_seq.sv
// Directed bench for fc_cif_udiv_64ns_32ns_seq (follows FC_CIF_UDIV_RADIX4_EN
// through the package latency constant).
module tb_fc_cif_udiv_64ns_32ns_seq;
    import fc_cif_div_pkg::*;

    logic        clk;
    logic        reset;
    logic        ce;
    logic        start;
    logic [63:0] din0;
    logic [31:0] din1;
    logic        ready;
    logic        done;
    logic [63:0] quot;
    logic [31:0] rem;
    logic        div0;

    int n_assert = 0;
    int n_fail   = 0;

    fc_cif_udiv_64ns_32ns_seq dut (
        .clk  (clk),
        .reset(reset),
        .ce   (ce),
        .start(start),
        .din0 (din0),
        .din1 (din1),
        .ready(ready),
        .done (done),
        .quot (quot),
        .rem  (rem),
        .div0 (div0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [95:0] obs, input logic [95:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Start one op and count enabled+disabled edges until done is seen.
    // ce_off_at>0: ce low for the 10 edges after that edge.
    // pulse_at>0: junk start pulses (with junk operands) during BUSY.
    task automatic run_op(input logic [63:0] a, input logic [31:0] b,
                          input int ce_off_at, input int pulse_at, output int lat);
        ce = 1'b1; start = 1'b1; din0 = a; din1 = b;
        tick();
        start = 1'b0;
        lat = -1;
        for (int k = 1; k <= 200; k++) begin
            ce = !(ce_off_at > 0 && k > ce_off_at && k <= ce_off_at + 10);
            if (pulse_at > 0 && (k == pulse_at || k == pulse_at + 4)) begin
                start = 1'b1; din0 = 64'hDEAD_BEEF; din1 = 32'd2;
            end else begin
                start = 1'b0; din0 = a; din1 = b;
            end
            tick();
            if (done) begin
                lat = k;
                break;
            end
        end
        ce = 1'b1; start = 1'b0;
        $display("op 0x%0h / 0x%0h : latency %0d quot 0x%0h rem 0x%0h div0 %0b",
                 a, b, lat, quot, rem, div0);
    endtask

    int          lat;
    bit          seen;
    logic [63:0] ra;
    logic [31:0] rb;
    logic [95:0] recon;

    initial begin
        reset = 1'b1; ce = 1'b1; start = 1'b0; din0 = '0; din1 = '0;
        tick();
        tick();
        check("rst_ready", 96'(ready), 96'(1));
        check("rst_done",  96'(done),  96'(0));
        check("rst_quot",  96'(quot),  96'(0));
        check("rst_rem",   96'(rem),   96'(0));
        check("rst_div0",  96'(div0),  96'(0));
        reset = 1'b0;
        tick();

        // 1000 / 7 = 142 r 6
        run_op(64'd1000, 32'd7, 0, 0, lat);
        check("op1_lat",  96'(lat),  96'(LATENCY));
        check("op1_quot", 96'(quot), 96'(142));
        check("op1_rem",  96'(rem),  96'(6));
        check("op1_div0", 96'(div0), 96'(0));
        tick();
        check("op1_done_pulse", 96'(done), 96'(0));
        check("op1_quot_hold",  96'(quot), 96'(142));

        // (2^64-1)/(2^32-1) = 2^32+1 exactly
        run_op(64'hFFFF_FFFF_FFFF_FFFF, 32'hFFFF_FFFF, 0, 0, lat);
        check("max_quot", 96'(quot), 96'(64'h1_0000_0001));
        check("max_rem",  96'(rem),  96'(0));

        run_op(64'h0123_4567_89AB_CDEF, 32'd1, 0, 0, lat);
        check("div1_quot", 96'(quot), 96'(64'h0123_4567_89AB_CDEF));
        check("div1_rem",  96'(rem),  96'(0));

        // Divide by zero
        run_op(64'h1234_5678_9ABC_DEF0, 32'd0, 0, 0, lat);
        check("dz_lat",  96'(lat),  96'(2));
        check("dz_quot", 96'(quot), 96'(64'hFFFF_FFFF_FFFF_FFFF));
        check("dz_rem",  96'(rem),  96'(32'h9ABC_DEF0));
        check("dz_div0", 96'(div0), 96'(1));

        // 100 / 3 = 33 r 1, with junk start pulses while BUSY
        run_op(64'd100, 32'd3, 0, 5, lat);
        check("ign_lat",  96'(lat),  96'(LATENCY));
        check("ign_quot", 96'(quot), 96'(33));
        check("ign_rem",  96'(rem),  96'(1));
        check("ign_div0", 96'(div0), 96'(0));

        // ce low for 10 edges mid-BUSY stretches latency by 10
        run_op(64'd1000, 32'd7, 20, 0, lat);
        check("ce_lat",  96'(lat),  96'(LATENCY + 10));
        check("ce_quot", 96'(quot), 96'(142));
        ce = 1'b0;
        tick();
        check("ce_done_hold1", 96'(done), 96'(1));
        tick();
        check("ce_done_hold2", 96'(done), 96'(1));
        ce = 1'b1;
        tick();
        check("ce_done_clear", 96'(done), 96'(0));

        // Back-to-back: second start presented in the DONE cycle
        start = 1'b1; din0 = 64'd200; din1 = 32'd9;
        tick();
        start = 1'b0;
        for (int i = 1; i < LATENCY; i++) tick();
        check("b2b_ready_done", 96'(ready), 96'(1));
        check("b2b_done_early", 96'(done),  96'(0));
        start = 1'b1; din0 = 64'd77; din1 = 32'd4;
        tick();
        start = 1'b0;
        check("b2b_done1", 96'(done), 96'(1));
        check("b2b_quot1", 96'(quot), 96'(22));
        check("b2b_rem1",  96'(rem),  96'(2));
        lat = -1;
        for (int k = 1; k <= 200; k++) begin
            tick();
            if (done) begin
                lat = k;
                break;
            end
        end
        $display("b2b second op: latency %0d quot 0x%0h rem 0x%0h", lat, quot, rem);
        check("b2b_lat2",  96'(lat),  96'(LATENCY));
        check("b2b_quot2", 96'(quot), 96'(19));
        check("b2b_rem2",  96'(rem),  96'(1));

        // Reset during BUSY aborts with no done
        tick();
        start = 1'b1; din0 = 64'd1000; din1 = 32'd7;
        tick();
        start = 1'b0;
        for (int i = 1; i <= 20; i++) tick();
        check("abort_busy", 96'(ready), 96'(0));
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("abort_ready", 96'(ready), 96'(1));
        check("abort_done",  96'(done),  96'(0));
        check("abort_quot",  96'(quot),  96'(0));
        seen = 1'b0;
        for (int i = 0; i < LATENCY + 5; i++) begin
            tick();
            if (done) seen = 1'b1;
        end
        check("abort_no_done", 96'(seen), 96'(0));
        run_op(64'd50, 32'd5, 0, 0, lat);
        check("post_lat",  96'(lat),  96'(LATENCY));
        check("post_quot", 96'(quot), 96'(10));
        check("post_rem",  96'(rem),  96'(0));

        // Random operands against the bench's own division
        for (int n = 0; n < 100; n++) begin
            ra = {$urandom, $urandom};
            rb = $urandom >> $urandom_range(0, 31);
            if (rb == '0) rb = 32'd1;
            run_op(ra, rb, 0, 0, lat);
            recon = 96'(quot) * 96'(rb) + 96'(rem);
            check("rnd_quot",  96'(quot), 96'(ra / {32'd0, rb}));
            check("rnd_rem",   96'(rem),  96'(ra % {32'd0, rb}));
            check("rnd_recon", recon,     96'(ra));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
